// File: rtl/instr_fetch_unit.sv
// Fetch stage: credit-limited sequential PC requests, in-order prefetch FIFO, redirect flush/drain.
// Optional macro FETCH_BYPASS_EN adds a same-cycle response-to-core path when the FIFO is empty.
module instr_fetch_unit #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32,
   parameter int FIFO_DEPTH = 4,
   parameter logic [ADDR_WIDTH-1:0] RESET_PC = '0
) (
   input  logic                  clk,
   input  logic                  rst,
   output logic                  imem_req_valid,
   input  logic                  imem_req_ready,
   output logic [ADDR_WIDTH-1:0] imem_req_addr,
   input  logic                  imem_resp_valid,
   input  logic [DATA_WIDTH-1:0] imem_resp_data,
   output logic                  if_valid,
   input  logic                  if_ready,
   output logic [DATA_WIDTH-1:0] if_instr,
   output logic [ADDR_WIDTH-1:0] if_pc,
   input  logic                  redirect_valid,
   input  logic [ADDR_WIDTH-1:0] redirect_pc
);

   localparam int CW = $clog2(FIFO_DEPTH + 1);
   localparam int PW = $clog2(FIFO_DEPTH);

   typedef enum logic {FETCH, DRAIN} state_t;

   state_t                state, state_nxt;
   logic                  req_en;
   logic [ADDR_WIDTH-1:0] fetch_pc, resp_pc, redirect_target;
   logic [CW-1:0]         outstanding, outstanding_nxt, drop_cnt, drop_nxt, fifo_count;
   logic [PW-1:0]         wr_ptr, rd_ptr;
   logic [CW:0]           credit_used;
   logic                  req_fire, resp_ok, fifo_empty, bypass, push, pop;

   logic [DATA_WIDTH-1:0] instr_mem [FIFO_DEPTH];
   logic [ADDR_WIDTH-1:0] pc_mem    [FIFO_DEPTH];

   // Both channels transfer on a cycle where valid && ready are high; the
   // response channel has no ready and is accepted whenever a request is owed.
   assign credit_used     = {1'b0, outstanding} + {1'b0, fifo_count};
   assign imem_req_valid  = req_en && (state == FETCH) && (credit_used < (CW+1)'(FIFO_DEPTH));
   assign imem_req_addr   = fetch_pc;
   assign req_fire        = imem_req_valid && imem_req_ready;
   assign resp_ok         = imem_resp_valid && (outstanding != '0);
   assign fifo_empty      = (fifo_count == '0);
   assign redirect_target = redirect_pc & ~ADDR_WIDTH'(3);
   assign outstanding_nxt = outstanding + CW'(req_fire) - CW'(resp_ok);

`ifdef FETCH_BYPASS_EN
   assign bypass = fifo_empty && (state == FETCH) && !redirect_valid && resp_ok;
`else
   assign bypass = 1'b0;
`endif

   assign push = resp_ok && (state == FETCH) && !redirect_valid && !(bypass && if_ready);
   assign pop  = !fifo_empty && if_ready;

   always_comb begin
      if_valid = !fifo_empty || bypass;
      if_instr = '0;
      if_pc    = '0;
      if (!fifo_empty) begin
         if_instr = instr_mem[rd_ptr];
         if_pc    = pc_mem[rd_ptr];
      end else if (bypass) begin
         if_instr = imem_resp_data;
         if_pc    = resp_pc;
      end
   end

   // Stale requests (including one accepted alongside the redirect) are counted into drop_cnt.
   always_comb begin
      state_nxt = state;
      drop_nxt  = drop_cnt;
      if (redirect_valid) begin
         drop_nxt  = outstanding_nxt;
         state_nxt = (outstanding_nxt != '0) ? DRAIN : FETCH;
      end else if (state == DRAIN && resp_ok) begin
         if (drop_cnt != '0) drop_nxt = drop_cnt - CW'(1);
         if (drop_cnt <= CW'(1)) state_nxt = FETCH;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= FETCH;
         req_en      <= 1'b0;
         fetch_pc    <= RESET_PC;
         resp_pc     <= RESET_PC;
         outstanding <= '0;
         drop_cnt    <= '0;
         fifo_count  <= '0;
         wr_ptr      <= '0;
         rd_ptr      <= '0;
      end else begin
         state       <= state_nxt;
         req_en      <= 1'b1;
         outstanding <= outstanding_nxt;
         drop_cnt    <= drop_nxt;
         if (redirect_valid) begin
            fetch_pc   <= redirect_target;
            resp_pc    <= redirect_target;
            fifo_count <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
         end else begin
            if (req_fire) fetch_pc <= fetch_pc + ADDR_WIDTH'(4);
            if (state == FETCH && resp_ok) resp_pc <= resp_pc + ADDR_WIDTH'(4);
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop) rd_ptr <= rd_ptr + PW'(1);
            fifo_count <= fifo_count + CW'(push) - CW'(pop);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         instr_mem[wr_ptr] <= imem_resp_data;
         pc_mem[wr_ptr]    <= resp_pc;
      end
   end

   // A response with nothing owed is a memory protocol error; it is ignored above.
   assert property (@(posedge clk) disable iff (rst) !(imem_resp_valid && outstanding == '0));

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: memory model, scoreboard of expected {pc, instr}, redirect vector table.
module tb_instr_fetch_unit;
   localparam int AW = 32;
   localparam int DW = 32;
   localparam logic [31:0] RESET_PC = 32'h0;
`ifdef FETCH_BYPASS_EN
   localparam logic BYP = 1'b1;
`else
   localparam logic BYP = 1'b0;
`endif

   logic          clk, rst;
   logic          imem_req_valid, imem_req_ready, imem_resp_valid;
   logic [AW-1:0] imem_req_addr;
   logic [DW-1:0] imem_resp_data, if_instr;
   logic          if_valid, if_ready, redirect_valid;
   logic [AW-1:0] if_pc, redirect_pc;

   instr_fetch_unit #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .FIFO_DEPTH(4), .RESET_PC(RESET_PC)) dut (
      .clk(clk), .rst(rst),
      .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
      .imem_resp_valid(imem_resp_valid), .imem_resp_data(imem_resp_data),
      .if_valid(if_valid), .if_ready(if_ready), .if_instr(if_instr), .if_pc(if_pc),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] target;
      logic [31:0] exp_first;
      logic [31:0] exp_second;
      int          mem_pct;
      int          resp_pct;
      int          rdy_pct;
   } vec_t;
   vec_t vecs[4];

   logic [63:0] exp_q[$];
   logic [31:0] pend_q[$];
   int          checks, errors;
   int          mem_pct, resp_pct, rdy_pct;
   int          n_req, n_out, post_cnt;
   logic [31:0] exp_addr, last_req_addr, first_out_pc;
   logic [31:0] post_addr[2];
   logic        first_out_seen, s_if_valid, s_req_valid, s_resp, s_req_fire;

   function automatic logic [31:0] instr_of(input logic [31:0] a);
      return (a * 32'h9E3779B1) ^ 32'h5A5A0F0F;
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // driver: one clock cycle; inputs driven at negedge, outputs sampled 1ns later
   task automatic cycle(input logic redir, input logic [31:0] rpc);
      logic [31:0] a;
      logic [63:0] e;
      @(negedge clk);
      imem_req_ready = (int'($urandom_range(99)) < mem_pct);
      if (pend_q.size() != 0 && int'($urandom_range(99)) < resp_pct) begin
         a = pend_q.pop_front();
         imem_resp_valid = 1'b1;
         imem_resp_data  = instr_of(a);
      end else begin
         imem_resp_valid = 1'b0;
         imem_resp_data  = $urandom;
      end
      if_ready       = (int'($urandom_range(99)) < rdy_pct);
      redirect_valid = redir;
      redirect_pc    = rpc;
      #1;
      s_resp      = imem_resp_valid;
      s_if_valid  = if_valid;
      s_req_valid = imem_req_valid;
      s_req_fire  = imem_req_valid && imem_req_ready;
      if (if_valid && if_ready) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_out: got pc %h instr %h expected none", if_pc, if_instr);
         end else begin
            e = exp_q.pop_front();
            check("out_pc_instr", {if_pc, if_instr}, e);
         end
         if (!first_out_seen) begin
            first_out_seen = 1'b1;
            first_out_pc   = if_pc;
         end
         n_out++;
      end
      if (s_req_fire) begin
         check("req_addr", 64'(imem_req_addr), 64'(exp_addr));
         pend_q.push_back(imem_req_addr);
         last_req_addr = imem_req_addr;
         n_req++;
         if (!redir) begin
            exp_q.push_back({exp_addr, instr_of(exp_addr)});
            if (post_cnt < 2) post_addr[post_cnt] = imem_req_addr;
            post_cnt++;
         end
         exp_addr = exp_addr + 32'd4;
      end
      if (redir) begin
         exp_q.delete();
         exp_addr       = rpc & ~32'h3;
         post_cnt       = 0;
         first_out_seen = 1'b0;
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst             = 1'b1;
      imem_req_ready  = 1'b0;
      imem_resp_valid = 1'b0;
      if_ready        = 1'b0;
      redirect_valid  = 1'b0;
      pend_q.delete();
      exp_q.delete();
      exp_addr       = RESET_PC;
      post_cnt       = 0;
      first_out_seen = 1'b0;
      #1;
      check("rst_req_valid", 64'(imem_req_valid), 64'(0));
      check("rst_req_addr", 64'(imem_req_addr), 64'(RESET_PC));
      check("rst_if_valid", 64'(if_valid), 64'(0));
      check("rst_if_instr", 64'(if_instr), 64'(0));
      check("rst_if_pc", 64'(if_pc), 64'(0));
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int n0, o0;
      vecs[0] = '{32'h00000100, 32'h00000100, 32'h00000104, 100, 100, 100};
      vecs[1] = '{32'h00000203, 32'h00000200, 32'h00000204, 60, 70, 50};
      vecs[2] = '{32'hFFFFFFFC, 32'hFFFFFFFC, 32'h00000000, 80, 50, 30};
      vecs[3] = '{32'h00001001, 32'h00001000, 32'h00001004, 50, 90, 80};
      checks = 0; errors = 0; n_req = 0; n_out = 0;
      rst = 1'b1; redirect_pc = '0; imem_resp_data = '0;

      // sequential fetch, latency of the first response, steady-state throughput
      do_reset();
      mem_pct = 100; resp_pct = 100; rdy_pct = 100;
      for (int k = 0; k < 20; k++) begin
         cycle(1'b0, '0);
         if (s_resp) break;
      end
      check("first_resp_seen", 64'(s_resp), 64'(1));
      check("first_resp_if_valid", 64'(s_if_valid), 64'(BYP));
      for (int k = 0; k < 10; k++) cycle(1'b0, '0);
      o0 = n_out;
      for (int k = 0; k < 20; k++) cycle(1'b0, '0);
      check("steady_throughput", 64'(n_out - o0), 64'(20));
      check("first_pc", 64'(first_out_pc), 64'(RESET_PC));

      // backpressure: credit limit, in-order drain, resume at 0x10
      do_reset();
      rdy_pct = 0;
      n0 = n_req;
      for (int k = 0; k < 20; k++) cycle(1'b0, '0);
      check("credit_requests", 64'(n_req - n0), 64'(4));
      check("credit_req_valid", 64'(s_req_valid), 64'(0));
      rdy_pct = 100;
      for (int k = 0; k < 20 && n_req == n0 + 4; k++) cycle(1'b0, '0);
      check("resume_addr", 64'(last_req_addr), 64'(32'h10));
      check("drain_first_pc", 64'(first_out_pc), 64'(RESET_PC));

      // reset with three buffered entries
      do_reset();
      rdy_pct = 0;
      for (int k = 0; k < 20; k++) cycle(1'b0, '0);
      mem_pct = 0; rdy_pct = 100;
      cycle(1'b0, '0);
      rdy_pct = 0;
      cycle(1'b0, '0);
      check("three_held_valid", 64'(s_if_valid), 64'(1));
      do_reset();
      mem_pct = 100; rdy_pct = 100;
      n0 = n_req;
      for (int k = 0; k < 10 && n_req == n0; k++) cycle(1'b0, '0);
      check("req_after_reset", 64'(last_req_addr), 64'(RESET_PC));

      // redirect with two outstanding, no same-cycle events
      do_reset();
      resp_pct = 0;
      n0 = n_req;
      for (int k = 0; k < 10 && n_req < n0 + 2; k++) cycle(1'b0, '0);
      check("two_outstanding", 64'(n_req - n0), 64'(2));
      mem_pct = 0;
      cycle(1'b1, 32'h100);
      mem_pct = 100;
      cycle(1'b0, '0);
      check("flush_if_valid", 64'(s_if_valid), 64'(0));
      check("drain_req_valid", 64'(s_req_valid), 64'(0));
      resp_pct = 100;
      for (int k = 0; k < 50 && !first_out_seen; k++) cycle(1'b0, '0);
      check("redir_first_pc", 64'(first_out_pc), 64'(32'h100));

      // redirect coinciding with a response and a request handshake
      for (int k = 0; k < 10; k++) cycle(1'b0, '0);
      cycle(1'b1, 32'h400);
      check("same_cycle_resp", 64'(s_resp), 64'(1));
      check("same_cycle_req", 64'(s_req_fire), 64'(1));
      for (int k = 0; k < 50 && !first_out_seen; k++) cycle(1'b0, '0);
      check("same_cycle_first_pc", 64'(first_out_pc), 64'(32'h400));

      // table: random traffic, redirect, alignment and wrap of the new stream
      foreach (vecs[i]) begin
         mem_pct = vecs[i].mem_pct; resp_pct = vecs[i].resp_pct; rdy_pct = vecs[i].rdy_pct;
         for (int k = 0; k < 15; k++) cycle(1'b0, '0);
         cycle(1'b1, vecs[i].target);
         for (int k = 0; k < 200 && post_cnt < 2; k++) cycle(1'b0, '0);
         check("vec_post_count", 64'(post_cnt >= 2), 64'(1));
         check("vec_first_addr", 64'(post_addr[0]), 64'(vecs[i].exp_first));
         check("vec_second_addr", 64'(post_addr[1]), 64'(vecs[i].exp_second));
         mem_pct = 0; resp_pct = 100; rdy_pct = 100;
         for (int k = 0; k < 100 && (exp_q.size() != 0 || pend_q.size() != 0); k++) cycle(1'b0, '0);
         check("vec_drained", 64'(exp_q.size()), 64'(0));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
